// File: rtl/dual_issue_buffer_pkg.sv
// rtl/dual_issue_buffer_pkg.sv - shared opcode constants, field positions and decode helpers
// Purpose: constants and small decode functions used by the dual-issue buffer
//          and its pairing checker.
// Ports:   none (package).
package dual_issue_buffer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;  // low bound of the rt-writing immediate group
  localparam logic [5:0] OP_LUI   = 6'h0F;  // high bound of the rt-writing immediate group
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  localparam logic [4:0] REG_RA = 5'd31;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[FN_MSB:FN_LSB];
  endfunction

  function automatic logic is_ctrl(input logic [31:0] instr);
    logic [5:0] op;
    op = opcode_of(instr);
    return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE) ||
           ((op == OP_RTYPE) && (funct_of(instr) == FN_JR));
  endfunction

  // Loads/stores are recognised by the top opcode bit.
  function automatic logic is_mem(input logic [31:0] instr);
    return instr[OP_MSB];
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] instr);
    logic [5:0] op;
    op = opcode_of(instr);
    if (op == OP_RTYPE)
      return (funct_of(instr) == FN_JR) ? 5'd0 : instr[RD_MSB:RD_LSB];
    else if (((op >= OP_ADDI) && (op <= OP_LUI)) || (op == OP_LW))
      return instr[RT_MSB:RT_LSB];
    else if (op == OP_JAL)
      return REG_RA;
    else
      return 5'd0;
  endfunction

endpackage

// File: rtl/dual_issue_buffer_pair_check.sv
// rtl/dual_issue_buffer_pair_check.sv - combinational legality check for co-issuing two instructions
// Purpose: decides whether the younger instruction may issue beside the older.
// Ports:   instr_1  in  IW  older instruction (decode slot 1 candidate)
//          instr_2  in  IW  younger instruction (decode slot 2 candidate)
//          pair_ok  out 1   both may issue together
//          dest_1   out 5   destination register of instr_1 (0 = none)
//          dest_2   out 5   destination register of instr_2 (0 = none)
import dual_issue_buffer_pkg::*;

module pair_check #(
  parameter int IW = 32
) (
  input  logic [IW-1:0] instr_1,
  input  logic [IW-1:0] instr_2,
  output logic          pair_ok,
  output logic [4:0]    dest_1,
  output logic [4:0]    dest_2
);

  logic raw, waw, both_mem, any_ctrl;

  always_comb begin
    dest_1   = dest_of(instr_1[31:0]);
    dest_2   = dest_of(instr_2[31:0]);
    raw      = (dest_1 != 5'd0) &&
               ((instr_2[RS_MSB:RS_LSB] == dest_1) || (instr_2[RT_MSB:RT_LSB] == dest_1));
    waw      = (dest_1 != 5'd0) && (dest_2 == dest_1);
    both_mem = is_mem(instr_1[31:0]) && is_mem(instr_2[31:0]);
    any_ctrl = is_ctrl(instr_1[31:0]) || is_ctrl(instr_2[31:0]);
    pair_ok  = !(raw || waw || both_mem || any_ctrl);
  end

endmodule

// File: rtl/dual_issue_buffer.sv
// rtl/dual_issue_buffer.sv - fetch-to-decode instruction buffer with dual-issue pairing
// Purpose: circular buffer taking up to two fetched instructions per cycle and
//          loading one or two in-order instructions into registered decode slots.
// Optional: define ISSUE_STATS_EN to add dual_cnt / single_cnt issue counters.
// Ports:   clk, rst                       clock, async active-high reset
//          fetch_valid[1:0]               instr0 / instr1 present
//          fetch_instr0/1, fetch_pc0/1    fetched instructions and PCs
//          fetch_ready                    room for two instructions
//          stall_D, flush                 decode stall, redirect
//          valid_D1/2, instr_D1/2, pc_D1/2 decode slot contents
//          rs_D1/2, rt_D1/2               source fields, 0 when slot invalid
//          dual_cnt, single_cnt           issue statistics (ISSUE_STATS_EN only)
import dual_issue_buffer_pkg::*;

module dual_issue_buffer #(
  parameter int DEPTH = 8,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    fetch_valid,
  input  logic [IW-1:0] fetch_instr0,
  input  logic [IW-1:0] fetch_instr1,
  input  logic [IW-1:0] fetch_pc0,
  input  logic [IW-1:0] fetch_pc1,
  output logic          fetch_ready,
  input  logic          stall_D,
  input  logic          flush,
  output logic          valid_D1,
  output logic          valid_D2,
  output logic [IW-1:0] instr_D1,
  output logic [IW-1:0] instr_D2,
  output logic [IW-1:0] pc_D1,
  output logic [IW-1:0] pc_D2,
  output logic [4:0]    rs_D1,
  output logic [4:0]    rt_D1,
  output logic [4:0]    rs_D2,
  output logic [4:0]    rt_D2
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]   dual_cnt,
  output logic [31:0]   single_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;  // count must reach DEPTH itself

  logic [IW-1:0] instr_mem [DEPTH];
  logic [IW-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] head, tail, head_p1, tail_p1;
  logic [CW-1:0] count;
  logic          push_en;
  logic [1:0]    push_n, pushed, issue_n;
  logic          pair_ok;
  logic [4:0]    dest_1, dest_2;
  logic          unused_dest;

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  // Credit is judged on the registered count only; a same-cycle pop does not help.
  assign fetch_ready = (CW'(DEPTH) - count) >= CW'(2);
  assign push_en     = fetch_ready && !flush;

  pair_check #(.IW(IW)) u_pair_check (
    .instr_1 (instr_mem[head]),
    .instr_2 (instr_mem[head_p1]),
    .pair_ok (pair_ok),
    .dest_1  (dest_1),
    .dest_2  (dest_2)
  );

  // Destinations are not consumed by the buffer itself.
  assign unused_dest = ^{dest_1, dest_2};

  always_comb begin
    push_n = {1'b0, fetch_valid[0]} + {1'b0, fetch_valid[1]};
    pushed = push_en ? push_n : 2'd0;
    if (stall_D || flush || (count == '0))
      issue_n = 2'd0;
    else if ((count >= CW'(2)) && pair_ok)
      issue_n = 2'd2;
    else
      issue_n = 2'd1;
  end

  // Storage is not reset: validity is tracked entirely by head/count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      if (fetch_valid[0]) begin
        instr_mem[tail] <= fetch_instr0;
        pc_mem[tail]    <= fetch_pc0;
      end
      if (fetch_valid[1]) begin
        instr_mem[tail_p1] <= fetch_instr1;
        pc_mem[tail_p1]    <= fetch_pc1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid_D1 <= 1'b0;
      valid_D2 <= 1'b0;
      instr_D1 <= '0;
      instr_D2 <= '0;
      pc_D1    <= '0;
      pc_D2    <= '0;
    end else begin
      tail  <= tail + AW'(pushed);
      head  <= head + AW'(issue_n);
      count <= count + CW'(pushed) - CW'(issue_n);
      if (!stall_D) begin
        valid_D1 <= (issue_n != 2'd0);
        instr_D1 <= (issue_n != 2'd0) ? instr_mem[head] : '0;
        pc_D1    <= (issue_n != 2'd0) ? pc_mem[head]    : '0;
        valid_D2 <= (issue_n == 2'd2);
        instr_D2 <= (issue_n == 2'd2) ? instr_mem[head_p1] : '0;
        pc_D2    <= (issue_n == 2'd2) ? pc_mem[head_p1]    : '0;
      end
    end
  end

  assign rs_D1 = valid_D1 ? instr_D1[RS_MSB:RS_LSB] : 5'd0;
  assign rt_D1 = valid_D1 ? instr_D1[RT_MSB:RT_LSB] : 5'd0;
  assign rs_D2 = valid_D2 ? instr_D2[RS_MSB:RS_LSB] : 5'd0;
  assign rt_D2 = valid_D2 ? instr_D2[RT_MSB:RT_LSB] : 5'd0;

`ifdef ISSUE_STATS_EN
  // issue_n is already 0 on stalled or flushed edges, so flush leaves the counts alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dual_cnt   <= '0;
      single_cnt <= '0;
    end else begin
      if ((issue_n == 2'd2) && (dual_cnt != 32'hFFFF_FFFF))
        dual_cnt <= dual_cnt + 32'd1;
      if ((issue_n == 2'd1) && (single_cnt != 32'hFFFF_FFFF))
        single_cnt <= single_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_buffer.sv
// tb/tb_dual_issue_buffer.sv - directed self-checking bench for dual_issue_buffer
module tb_dual_issue_buffer;

  logic        clk, rst, stall_D, flush, fetch_ready;
  logic [1:0]  fetch_valid;
  logic [31:0] fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1;
  logic        valid_D1, valid_D2;
  logic [31:0] instr_D1, instr_D2, pc_D1, pc_D2;
  logic [4:0]  rs_D1, rt_D1, rs_D2, rt_D2;
`ifdef ISSUE_STATS_EN
  logic [31:0] dual_cnt, single_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] I_SUB  = 32'h0085_3022;  // sub $6,$4,$5
  localparam logic [31:0] I_LW   = 32'h8C28_0000;  // lw $8,0($1)
  localparam logic [31:0] I_ADD9 = 32'h0102_4820;  // add $9,$8,$2
  localparam logic [31:0] I_SW   = 32'hAC23_0004;  // sw $3,4($1)
  localparam logic [31:0] I_BEQ  = 32'h1022_0004;  // beq $1,$2,4
  localparam logic [31:0] I_ADDI = 32'h20C5_0001;  // addi $5,$6,1

  dual_issue_buffer #(.DEPTH(8), .IW(32)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
    .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
    .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1), .fetch_ready(fetch_ready),
    .stall_D(stall_D), .flush(flush),
    .valid_D1(valid_D1), .valid_D2(valid_D2),
    .instr_D1(instr_D1), .instr_D2(instr_D2), .pc_D1(pc_D1), .pc_D2(pc_D2),
    .rs_D1(rs_D1), .rt_D1(rt_D1), .rs_D2(rs_D2), .rt_D2(rt_D2)
`ifdef ISSUE_STATS_EN
    , .dual_cnt(dual_cnt), .single_cnt(single_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // addi $rt,$0,imm : independent of any other such instruction with a different rt
  function automatic logic [31:0] addi_enc(input int rt, input int imm);
    return {6'h08, 5'd0, 5'(rt), 16'(imm)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] p0, input logic [31:0] p1);
    fetch_valid = v; fetch_instr0 = i0; fetch_instr1 = i1; fetch_pc0 = p0; fetch_pc1 = p1;
  endtask

  task automatic idle();
    fetch_valid = 2'b00;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (valid_D1 !== 1'b0) begin n_fail++; $display("FAIL rst_valid_D1 got %0b want 0", valid_D1); end
    n_tests++; if (valid_D2 !== 1'b0) begin n_fail++; $display("FAIL rst_valid_D2 got %0b want 0", valid_D2); end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_ready got %0b want 1", fetch_ready); end
    n_tests++; if ({instr_D1, pc_D2, rs_D1, rt_D2} !== '0) begin n_fail++; $display("FAIL rst_slot_zero got %h want 0", {instr_D1, pc_D2, rs_D1, rt_D2}); end
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    stall_D = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      push(2'b11, addi_enc(2*k, k), addi_enc(2*k+1, k), 32'h10*k, 32'h10*k+4);
      step();
    end
    idle(); stall_D = 1'b0;
    step();
    n_tests++; if (instr_D1 !== addi_enc(2, 1)) begin n_fail++; $display("FAIL mid_pre_instr_D1 got %h want %h", instr_D1, addi_enc(2, 1)); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (valid_D1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid_D1 got %0b want 0", valid_D1); end
    n_tests++; if (valid_D2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid_D2 got %0b want 0", valid_D2); end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_fetch_ready got %0b want 1", fetch_ready); end
    #1 rst = 1'b0;
    push(2'b11, addi_enc(20, 7), addi_enc(21, 7), 32'h200, 32'h204);
    step();
    idle();
    step();
    n_tests++; if (instr_D1 !== addi_enc(20, 7)) begin n_fail++; $display("FAIL mid_after_instr_D1 got %h want %h", instr_D1, addi_enc(20, 7)); end
    n_tests++; if (instr_D2 !== addi_enc(21, 7)) begin n_fail++; $display("FAIL mid_after_instr_D2 got %h want %h", instr_D2, addi_enc(21, 7)); end
    step();
  endtask

  task automatic test_independent_pair();
    push(2'b11, I_ADD, I_SUB, 32'h100, 32'h104);
    step();
    idle();
    step();
    n_tests++; if ({valid_D1, valid_D2} !== 2'b11) begin n_fail++; $display("FAIL ind_valid got %b want 11", {valid_D1, valid_D2}); end
    n_tests++; if ({rs_D1, rt_D1} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL ind_rs_rt_D1 got %0d/%0d want 1/2", rs_D1, rt_D1); end
    n_tests++; if ({rs_D2, rt_D2} !== {5'd4, 5'd5}) begin n_fail++; $display("FAIL ind_rs_rt_D2 got %0d/%0d want 4/5", rs_D2, rt_D2); end
    n_tests++; if (pc_D2 !== 32'h104) begin n_fail++; $display("FAIL ind_pc_D2 got %h want 104", pc_D2); end
    step();
    n_tests++; if ({valid_D1, rs_D1} !== 6'd0) begin n_fail++; $display("FAIL ind_empty got %b/%0d want 0/0", valid_D1, rs_D1); end
  endtask

  task automatic test_raw_split();
    push(2'b11, I_LW, I_ADD9, 32'h300, 32'h304);
    step();
    idle();
    step();
    n_tests++; if ({valid_D1, valid_D2} !== 2'b10) begin n_fail++; $display("FAIL raw_c1_valid got %b want 10", {valid_D1, valid_D2}); end
    n_tests++; if (instr_D1 !== I_LW) begin n_fail++; $display("FAIL raw_c1_instr got %h want %h", instr_D1, I_LW); end
    n_tests++; if (rs_D2 !== 5'd0) begin n_fail++; $display("FAIL raw_c1_rs_D2 got %0d want 0", rs_D2); end
    step();
    n_tests++; if ({valid_D1, valid_D2, rs_D1} !== {2'b10, 5'd8}) begin n_fail++; $display("FAIL raw_c2 got %b%b rs %0d want 10 rs 8", valid_D1, valid_D2, rs_D1); end
  endtask

  task automatic test_mem_branch();
    push(2'b11, I_LW, I_SW, 32'h400, 32'h404);
    step();
    idle();
    step();
    n_tests++; if ({valid_D2, instr_D1} !== {1'b0, I_LW}) begin n_fail++; $display("FAIL mem_c1 got v2=%b %h want v2=0 %h", valid_D2, instr_D1, I_LW); end
    step();
    n_tests++; if ({valid_D2, instr_D1} !== {1'b0, I_SW}) begin n_fail++; $display("FAIL mem_c2 got v2=%b %h want v2=0 %h", valid_D2, instr_D1, I_SW); end
    push(2'b11, I_BEQ, I_ADDI, 32'h500, 32'h504);
    step();
    idle();
    step();
    n_tests++; if ({valid_D1, valid_D2, instr_D1} !== {2'b10, I_BEQ}) begin n_fail++; $display("FAIL br_c1 got %b%b %h want 10 %h", valid_D1, valid_D2, instr_D1, I_BEQ); end
    step();
    n_tests++; if ({valid_D1, valid_D2, instr_D1} !== {2'b10, I_ADDI}) begin n_fail++; $display("FAIL br_c2 got %b%b %h want 10 %h", valid_D1, valid_D2, instr_D1, I_ADDI); end
    n_tests++; if (rs_D1 !== 5'd6) begin n_fail++; $display("FAIL br_c2_rs got %0d want 6", rs_D1); end
  endtask

  task automatic test_full_stall();
    push(2'b11, addi_enc(12, 6), addi_enc(13, 6), 32'h600, 32'h604);
    step();
    push(2'b11, addi_enc(2, 1), addi_enc(3, 1), 32'h610, 32'h614);
    step();
    stall_D = 1'b1;
    for (int k = 2; k <= 3; k++) begin
      push(2'b11, addi_enc(2*k, k), addi_enc(2*k+1, k), 32'h600 + 32'h10*k, 32'h604 + 32'h10*k);
      step();
    end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_at6 got %0b want 1", fetch_ready); end
    push(2'b11, addi_enc(8, 4), addi_enc(9, 4), 32'h640, 32'h644);
    step();
    n_tests++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_at8 got %0b want 0", fetch_ready); end
    n_tests++; if ({instr_D1, instr_D2} !== {addi_enc(12, 6), addi_enc(13, 6)}) begin n_fail++; $display("FAIL full_frozen got %h %h", instr_D1, instr_D2); end
    push(2'b11, addi_enc(10, 5), addi_enc(11, 5), 32'h650, 32'h654);
    step();
    idle();
    n_tests++; if ({valid_D1, instr_D1} !== {1'b1, addi_enc(12, 6)}) begin n_fail++; $display("FAIL full_frozen2 got %b %h", valid_D1, instr_D1); end
    stall_D = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_tests++; if ({instr_D1, instr_D2} !== {addi_enc(2*k, k), addi_enc(2*k+1, k)}) begin n_fail++; $display("FAIL drain_%0d got %h %h want %h %h", k, instr_D1, instr_D2, addi_enc(2*k, k), addi_enc(2*k+1, k)); end
      if (k == 1) begin
        n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready got %0b want 1", fetch_ready); end
      end
    end
    step();
    n_tests++; if (valid_D1 !== 1'b0) begin n_fail++; $display("FAIL drain_lost_push got %0b want 0", valid_D1); end
  endtask

  task automatic test_flush();
    push(2'b11, addi_enc(16, 8), addi_enc(17, 8), 32'h700, 32'h704);
    step();
    push(2'b11, addi_enc(18, 9), addi_enc(19, 9), 32'h710, 32'h714);
    step();
    n_tests++; if (valid_D1 !== 1'b1) begin n_fail++; $display("FAIL fl_pre_valid got %0b want 1", valid_D1); end
    flush = 1'b1;
    push(2'b11, addi_enc(20, 10), addi_enc(21, 10), 32'h720, 32'h724);
    step();
    n_tests++; if ({valid_D1, valid_D2, rs_D1, rt_D1, rt_D2} !== '0) begin n_fail++; $display("FAIL fl_clear got %b%b %0d %0d %0d want all 0", valid_D1, valid_D2, rs_D1, rt_D1, rt_D2); end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %0b want 1", fetch_ready); end
    flush = 1'b0;
    idle();
    step();
    n_tests++; if ({valid_D1, valid_D2} !== 2'b00) begin n_fail++; $display("FAIL fl_dropped got %b want 00", {valid_D1, valid_D2}); end
    step();
    n_tests++; if (valid_D1 !== 1'b0) begin n_fail++; $display("FAIL fl_dropped2 got %0b want 0", valid_D1); end
  endtask

  initial begin
    rst = 1'b1; stall_D = 1'b0; flush = 1'b0;
    push(2'b00, '0, '0, '0, '0);
    test_reset();
    test_reset_mid();
    test_independent_pair();
    test_raw_split();
    test_mem_branch();
    test_full_stall();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_issue_buffer.md
Name: dual_issue_buffer

Overview:
- Instruction buffer and pairing stage between fetch and decode of the dual-issue pipeline.
- Accepts up to two fetched instructions per cycle into a circular buffer.
- Each cycle it selects one or two in-order instructions for decode slots 1 and 2, and holds them in registered decode-slot outputs. The rs/rt fields it produces drive the decode-stage forwarding and hazard logic.
- Slot 2 issues only if it is independent of slot 1 and structurally legal.

Parameters:
- DEPTH, 8, buffer entries; power of two, at least 4.
- IW, 32, instruction and PC width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fetch_valid  in  2  bit0 = instr0 present; bit1 = instr1 present (bit1 only with bit0)
- fetch_instr0, fetch_instr1  in  IW  fetched instructions, program order
- fetch_pc0, fetch_pc1  in  IW  their PCs
- fetch_ready  out  1  buffer can accept two instructions this cycle
- stall_D  in  1  decode stall from hazard unit
- flush  in  1  redirect; discard buffer and decode slots
- valid_D1, valid_D2  out  1  decode slot occupied
- instr_D1, instr_D2  out  IW  slot instructions
- pc_D1, pc_D2  out  IW  slot PCs
- rs_D1, rt_D1, rs_D2, rt_D2  out  5  instr[25:21] / instr[20:16] of each slot; 0 when the slot is invalid

Behaviour:
- Reset, asynchronous: buffer empty (head=tail=count=0); all valid_D*, instr_D*, pc_D*, rs/rt outputs = 0; fetch_ready = 1.
- Push:
  - Enabled when fetch_ready.
  - Writes instr0 at tail, then instr1 at tail+1 if bit1.
  - tail advances by popcount(fetch_valid), mod DEPTH.
  - fetch_ready = (DEPTH - count) >= 2, computed from registered count only; same-cycle pops are not credited.
  - Pushes while fetch_ready = 0 are ignored and lost; fetch must hold.
- Pop and decode-register load, on each edge with stall_D = 0 and flush = 0:
  - count = 0: valid_D1 = valid_D2 = 0.
  - count ≥ 1: slot 1 = entry[head], valid_D1 = 1.
  - Slot 2 = entry[head+1] when count ≥ 2 and pair_ok; otherwise valid_D2 = 0.
  - head advances by the number issued.
- pair_ok: false when any of the following holds.
  - RAW: dest(I1) ≠ 0 and (rs(I2) == dest(I1) or rt(I2) == dest(I1)).
  - WAW: dest(I1) ≠ 0 and dest(I2) == dest(I1).
  - Both instructions are memory ops: opcode[5] = 1.
  - I1 is a control transfer: opcode 0x02, 0x03, 0x04, 0x05, or opcode 0 with funct 0x08.
  - I2 is a control transfer.
- dest(I) rules:
  - opcode 0 → rd[15:11], except JR → 0.
  - opcodes 0x08–0x0F and 0x23 → rt.
  - 0x03 (JAL) → 31.
  - Otherwise → 0.
- Stall: decode registers and head hold; pushes continue if fetch_ready.
- Flush:
  - Takes priority over stall and push.
  - At the edge: head = tail = count = 0, all valid_D = 0, rs/rt = 0; incoming fetch data is dropped.
- count update: count_next = count + pushed − issued. Both may occur in the same cycle; count never exceeds DEPTH.
- Latency: an instruction pushed at edge k is in a decode slot at edge k+1 at the earliest. There is no empty-buffer bypass.
- Wrap-around: head and tail are log2(DEPTH)-bit pointers with natural wrap. Full versus empty is distinguished by count.

Optional Feature:
- ISSUE_STATS_EN
  - Defined: adds outputs dual_cnt and single_cnt, 32 bits each. On each non-stalled, non-flushed edge, dual_cnt increments when 2 instructions issue, and single_cnt when exactly 1. Both reset to 0, saturate at 0xFFFFFFFF, and are unaffected by flush.
  - Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ADDI..OP_LUI range bounds
  - FN_JR
  - field bit positions for rs, rt, rd and funct
  - REG_RA = 31
- One sub-module, pair_check: combinational; inputs are two instructions, outputs are pair_ok and dest of each.

Test Plan:
- Reset mid-operation: fill 6 entries, assert rst → immediately valid_D1 = valid_D2 = 0, fetch_ready = 1; the next push appears at head.
- Independent pair: push "add $3,$1,$2" and "sub $6,$4,$5" → next edge valid_D1 = valid_D2 = 1, rs_D1 = 1, rt_D1 = 2, rs_D2 = 4, rt_D2 = 5.
- RAW split: push "lw $8,0($1)" and "add $9,$8,$2" → first cycle slot 1 only; next cycle the add is in slot 1 with rs_D1 = 8.
- Memory and branch pairing:
  - Push "lw", "sw" → single issue each cycle.
  - Push "beq", "addi" → beq issues alone; addi issues next cycle.
- Full/stall: hold stall_D = 1 and push until count = 8 → fetch_ready = 0 at count ≥ 7; outputs are frozen. Release stall → pops resume and fetch_ready returns.
- Flush with simultaneous push: flush = 1 while fetch_valid = 2'b11 → next edge count = 0, valid_D1 = valid_D2 = 0, and the pushed instructions are absent.
